// File: rtl/bus_pkg.sv
// bus_pkg: shared state, master id, size encodings and request record for the memory arbiter
package bus_pkg;
  typedef enum logic [1:0] {IDLE, BUSY_IFU, BUSY_LSU} bus_state_t;
  localparam logic BUS_M_IFU = 1'b0;
  localparam logic BUS_M_LSU = 1'b1;
  localparam logic [1:0] BUS_SIZE_B = 2'd0;
  localparam logic [1:0] BUS_SIZE_H = 2'd1;
  localparam logic [1:0] BUS_SIZE_W = 2'd2;
  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } bus_req_t;
endpackage

// File: rtl/bus_req_slot.sv
// bus_req_slot: one-deep request holding register; a load while already pending is dropped
module bus_req_slot
  import bus_pkg::*;
(
  input  logic     clock,
  input  logic     reset,
  input  logic     load,
  input  logic     clear,
  input  bus_req_t req,
  output logic     pending,
  output bus_req_t fields
);
  // capture only into an empty slot; a grant empties it
  always_ff @(posedge clock)
    if (reset) begin
      pending <= 1'b0;
      fields <= '0;
    end else if (load && !pending) begin
      pending <= 1'b1;
      fields <= req;
    end else if (clear) pending <= 1'b0;
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master (IFU/LSU) to one memory bus arbiter, fixed LSU priority; BUS_ARBITER_TIMEOUT_EN adds a response watchdog
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ifu_reqValid,
  input  logic [31:0] ifu_addr,
  output logic        ifu_respValid,
  output logic [31:0] ifu_rdata,
  input  logic        lsu_reqValid,
  input  logic [31:0] lsu_addr,
  input  logic [1:0]  lsu_size,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_respValid,
  output logic [31:0] lsu_rdata,
  output logic        mem_reqValid,
  output logic [31:0] mem_addr,
  output logic [1:0]  mem_size,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_respValid,
  input  logic [31:0] mem_rdata,
  output logic        bus_err
);
  bus_state_t state;
  bus_req_t ifu_req, lsu_req, ifu_slot, lsu_slot, issue, hold, mem_req;
  logic ifu_pending, lsu_pending, grant, grant_id, done, timeout;
  logic [31:0] rdata_in;
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end
  assign ifu_req = '{addr: ifu_addr, size: BUS_SIZE_W, wen: 1'b0, wdata: '0, wmask: '0};
  assign lsu_req = '{addr: lsu_addr, size: lsu_size, wen: lsu_wen, wdata: lsu_wdata, wmask: lsu_wmask};
  bus_req_slot u_ifu_slot (
    .clock(clock), .reset(reset), .load(ifu_reqValid), .clear(grant && grant_id == BUS_M_IFU),
    .req(ifu_req), .pending(ifu_pending), .fields(ifu_slot)
  );
  bus_req_slot u_lsu_slot (
    .clock(clock), .reset(reset), .load(lsu_reqValid), .clear(grant && grant_id == BUS_M_LSU),
    .req(lsu_req), .pending(lsu_pending), .fields(lsu_slot)
  );
  // the idle cycle carrying a response pulse is skipped before the next grant
  assign grant = state == IDLE && (ifu_pending || lsu_pending) && !(ifu_respValid || lsu_respValid);
  assign grant_id = lsu_pending ? BUS_M_LSU : BUS_M_IFU;
  assign issue = grant_id == BUS_M_LSU ? lsu_slot : ifu_slot;
  assign mem_req = grant ? issue : hold;
  assign mem_reqValid = grant;
  assign mem_addr = mem_req.addr;
  assign mem_size = mem_req.size;
  assign mem_wen = mem_req.wen;
  assign mem_wdata = mem_req.wdata;
  assign mem_wmask = mem_req.wmask;
  assign done = state != IDLE && (mem_respValid || timeout);
  assign rdata_in = mem_respValid ? mem_rdata : TIMEOUT_RDATA;
`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  assign timeout = state != IDLE && !mem_respValid && cnt == CW'(TIMEOUT_CYCLES - 1);
  // watchdog counts busy cycles since issue; bus_err is sticky until reset
  always_ff @(posedge clock)
    if (reset) begin
      cnt <= '0;
      bus_err <= 1'b0;
    end else begin
      cnt <= grant ? '0 : (state != IDLE && !mem_respValid) ? cnt + 1'b1 : cnt;
      bus_err <= bus_err | timeout;
    end
`else
  assign timeout = 1'b0;
  assign bus_err = 1'b0;
`endif
  // arbitration FSM, request hold register and registered responses
  always_ff @(posedge clock)
    if (reset) begin
      state <= IDLE;
      hold <= '0;
      ifu_respValid <= 1'b0;
      lsu_respValid <= 1'b0;
      ifu_rdata <= '0;
      lsu_rdata <= '0;
    end else begin
      ifu_respValid <= done && state == BUSY_IFU;
      lsu_respValid <= done && state == BUSY_LSU;
      if (done && state == BUSY_IFU) ifu_rdata <= rdata_in;
      if (done && state == BUSY_LSU) lsu_rdata <= rdata_in;
      if (grant) hold <= issue;
      state <= grant ? (grant_id == BUS_M_LSU ? BUSY_LSU : BUSY_IFU) : done ? IDLE : state;
    end
endmodule
